// File: rtl/cmp_minmax_seq_if.sv
// Sample stream from a source into the min/max tracker (valid/ready handshake).
interface cmp_minmax_seq_if #(
    parameter int CMP_WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [CMP_WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/cmp_minmax_seq.sv
// Frame min/max tracker: one shared unsigned comparator, time-multiplexed between
// the running-max and running-min checks, reporting first-occurrence indices.
module cmp_minmax_seq #(
    parameter int CMP_WIDTH = 5,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] frame_len,
    cmp_minmax_seq_if.slave      stream,
    output logic                 busy,
    output logic                 done,
    output logic                 empty,
    output logic [CMP_WIDTH-1:0] max_val,
    output logic [CMP_WIDTH-1:0] min_val,
    output logic [CNT_WIDTH-1:0] max_idx,
    output logic [CNT_WIDTH-1:0] min_idx
);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        CMP_MAX,
        CMP_MIN,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [CMP_WIDTH-1:0] s_reg;
    logic [CMP_WIDTH-1:0] cmp_b;
    logic                 cmp_gt;
    logic                 cmp_lt;
    logic                 accept;
    logic                 last;

    // The single comparator: its reference operand follows the current phase.
    assign cmp_b   = (state == CMP_MAX) ? max_val : min_val;
    assign cmp_gt  = s_reg > cmp_b;
    assign cmp_lt  = s_reg < cmp_b;

    assign cnt_inc = cnt + CNT_WIDTH'(1);
    assign last    = (cnt_inc == len_q);
    assign accept  = (state == ACCEPT) && stream.in_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first; otherwise a path
    // that skips the assignment would infer a latch.
    always_comb begin
        state_next      = state;
        stream.in_ready = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (frame_len == '0) ? DONE : ACCEPT;
                end
            end
            ACCEPT: begin
                stream.in_ready = 1'b1;
                if (accept) begin
                    state_next = CMP_MAX;
                end
            end
            CMP_MAX: state_next = CMP_MIN;
            CMP_MIN: state_next = last ? DONE : ACCEPT;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q   <= '0;
            cnt     <= '0;
            s_reg   <= '0;
            empty   <= 1'b0;
            max_val <= '0;
            min_val <= '0;
            max_idx <= '0;
            min_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q   <= frame_len;
                        cnt     <= '0;
                        empty   <= (frame_len == '0);
                        max_val <= '0;
                        min_val <= '0;
                        max_idx <= '0;
                        min_idx <= '0;
                    end
                end
                ACCEPT: begin
                    if (accept) begin
                        s_reg <= stream.in_data;
                    end
                end
                CMP_MAX: begin
                    // Strict compare: equal samples keep the earlier index.
                    if (cnt == '0 || cmp_gt) begin
                        max_val <= s_reg;
                        max_idx <= cnt;
                    end
                end
                CMP_MIN: begin
                    if (cnt == '0 || cmp_lt) begin
                        min_val <= s_reg;
                        min_idx <= cnt;
                    end
                    cnt <= cnt_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_minmax_seq.sv
// Self-checking bench for cmp_minmax_seq: directed scenarios plus random frames
// compared against a queue-based extrema model.
module tb_cmp_minmax_seq;

    localparam int CW = 5;
    localparam int NW = 4;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          start     = 1'b0;
    logic [NW-1:0] frame_len = '0;
    logic          busy;
    logic          done;
    logic          empty;
    logic [CW-1:0] max_val;
    logic [CW-1:0] min_val;
    logic [NW-1:0] max_idx;
    logic [NW-1:0] min_idx;

    cmp_minmax_seq_if #(.CMP_WIDTH(CW)) stream ();

    cmp_minmax_seq #(.CMP_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .frame_len (frame_len),
        .stream    (stream),
        .busy      (busy),
        .done      (done),
        .empty     (empty),
        .max_val   (max_val),
        .min_val   (min_val),
        .max_idx   (max_idx),
        .min_idx   (min_idx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;
    int ready_seen  = 0;
    int ready_bad   = 0;

    logic [CW-1:0] frame_q[$];

    always @(negedge clk) begin
        if (done) done_pulses++;
        if (stream.in_ready) ready_seen++;
        if (stream.in_ready && (done || !busy)) ready_bad++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Extrema of the frame; first occurrence found by scanning from the end.
    task automatic model(output logic [CW-1:0] mx, output logic [CW-1:0] mn,
                         output logic [NW-1:0] mxi, output logic [NW-1:0] mni);
        mx = '0; mn = '0; mxi = '0; mni = '0;
        if (frame_q.size() != 0) begin
            mx = frame_q[0];
            mn = frame_q[0];
            foreach (frame_q[i]) begin
                if (frame_q[i] > mx) mx = frame_q[i];
                if (frame_q[i] < mn) mn = frame_q[i];
            end
            for (int i = frame_q.size() - 1; i >= 0; i--) begin
                if (frame_q[i] == mx) mxi = NW'(i);
                if (frame_q[i] == mn) mni = NW'(i);
            end
        end
    endtask

    task automatic send(input logic [CW-1:0] d, input int gap_max, input bit poke, input string name);
        int bud = 0;
        stream.in_valid = 1'b0;
        while (!stream.in_ready && bud < 20) begin
            start = poke;
            step();
            bud++;
        end
        checks++;
        if (stream.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout: in_ready=%b after %0d cycles, required 1", name, stream.in_ready, bud);
        end
        repeat ($urandom_range(gap_max, 0)) begin
            start = poke ? 1'($urandom) : 1'b0;
            stream.in_data = CW'($urandom);
            step();
            checks++;
            if (stream.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s ready_in_gap: in_ready=%b, required 1", name, stream.in_ready);
            end
        end
        start = poke;
        stream.in_valid = 1'b1;
        stream.in_data  = d;
        step();
        stream.in_valid = 1'b0;
        stream.in_data  = CW'($urandom);
    endtask

    task automatic run_frame(input int gap_max, input bit poke, input string name);
        logic [CW-1:0] mx, mn;
        logic [NW-1:0] mxi, mni;
        int pulses0, lat, exp_lat;
        model(mx, mn, mxi, mni);
        pulses0 = done_pulses;
        frame_len = NW'(frame_q.size());
        start = 1'b1;
        step();
        start = 1'b0;
        frame_len = NW'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b required 1", name, busy);
        end
        foreach (frame_q[i]) send(frame_q[i], gap_max, poke, name);
        exp_lat = (frame_q.size() == 0) ? 0 : 2;
        lat = 0;
        while (!done && lat < 10) begin
            start = poke;
            step();
            lat++;
        end
        checks++;
        if (done !== 1'b1 || lat != exp_lat) begin
            errors++;
            $display("FAIL %s done_latency: done=%b after %0d cycles, required 1 after %0d", name, done, lat, exp_lat);
        end
        checks++;
        if (max_val !== mx || max_idx !== mxi) begin
            errors++;
            $display("FAIL %s max: got %0d@%0d required %0d@%0d", name, max_val, max_idx, mx, mxi);
        end
        checks++;
        if (min_val !== mn || min_idx !== mni) begin
            errors++;
            $display("FAIL %s min: got %0d@%0d required %0d@%0d", name, min_val, min_idx, mn, mni);
        end
        checks++;
        if (empty !== (frame_q.size() == 0)) begin
            errors++;
            $display("FAIL %s empty: got %b required %b", name, empty, frame_q.size() == 0);
        end
        start = poke;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_pulses - pulses0 != 1) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b pulses=%0d, required 0 0 1", name, done, busy, done_pulses - pulses0);
        end
        step();
        checks++;
        if (max_val !== mx || min_val !== mn || max_idx !== mxi || min_idx !== mni) begin
            errors++;
            $display("FAIL %s results_held: got %0d@%0d %0d@%0d required %0d@%0d %0d@%0d",
                     name, max_val, max_idx, min_val, min_idx, mx, mxi, mn, mni);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({busy, done, empty, stream.in_ready, max_val, min_val, max_idx, min_idx} !== '0) begin
            errors++;
            $display("FAIL %s outputs_zero: busy=%b done=%b empty=%b rdy=%b max=%0d@%0d min=%0d@%0d, required all 0",
                     name, busy, done, empty, stream.in_ready, max_val, max_idx, min_val, min_idx);
        end
    endtask

    task automatic test_reset();
        stream.in_valid = 1'b0;
        stream.in_data  = '0;
        reset_n = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        reset_n = 1'b1;
        step();
        check_all_zero("reset_release");
    endtask

    task automatic test_back_to_back();
        frame_q = '{5'd3, 5'd2, 5'd9, 5'd11, 5'd11};
        run_frame(0, 1'b0, "back_to_back");
    endtask

    task automatic test_single();
        frame_q = '{5'd31};
        run_frame(0, 1'b0, "single");
    endtask

    task automatic test_empty();
        int seen0 = ready_seen;
        frame_q = {};
        run_frame(0, 1'b0, "empty");
        checks++;
        if (ready_seen != seen0) begin
            errors++;
            $display("FAIL empty in_ready_seen: got %0d cycles required 0", ready_seen - seen0);
        end
    endtask

    task automatic test_ties_gaps();
        frame_q = '{5'd7, 5'd7, 5'd7, 5'd7};
        run_frame(4, 1'b0, "ties_gaps");
    endtask

    task automatic test_start_ignored();
        frame_q = '{5'd5, 5'd1, 5'd8};
        run_frame(2, 1'b1, "start_ignored");
    endtask

    task automatic test_mid_reset();
        int pulses0 = done_pulses;
        frame_len = 4'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        send(5'd20, 0, 1'b0, "mid_reset");
        send(5'd3, 0, 1'b0, "mid_reset");
        #2 reset_n = 1'b0;
        #1 check_all_zero("mid_reset_async");
        repeat (4) step();
        reset_n = 1'b1;
        step();
        checks++;
        if (done_pulses != pulses0) begin
            errors++;
            $display("FAIL mid_reset no_done: got %0d pulses required 0", done_pulses - pulses0);
        end
        frame_q = '{5'd4, 5'd6};
        run_frame(0, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int n = (f == 0) ? 15 : int'($urandom_range(15, 0));
            frame_q = {};
            for (int i = 0; i < n; i++) frame_q.push_back(CW'($urandom_range(31, 0)));
            run_frame(3, 1'($urandom), $sformatf("random%0d", f));
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_empty();
        test_ties_gaps();
        test_start_ignored();
        test_mid_reset();
        test_random();
        checks++;
        if (ready_bad != 0) begin
            errors++;
            $display("FAIL ready_outside_accept: got %0d cycles required 0", ready_bad);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
